// File: rtl/fp32_pkg.sv
// Shared fp32 field positions, constants and scanner state encoding.
package fp32_pkg;

    localparam int          FP32_SIGN    = 31;
    localparam int          EXP_MSB      = 30;
    localparam int          EXP_LSB      = 23;
    localparam int          MANT_MSB     = 22;
    localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
    localparam logic [31:0] QNAN         = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FINAL,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } scan_state_e;

endpackage

// File: rtl/fp32_cmp.sv
// Total-order fp32 comparator: sign-magnitude mapped to an unsigned key, so -0 < +0.
module fp32_cmp
    import fp32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        a_lt_b,
    output logic        a_gt_b,
    output logic        a_nan,
    output logic        b_nan
);

    logic [31:0] key_a;
    logic [31:0] key_b;

    assign key_a  = a[FP32_SIGN] ? ~a : (a ^ 32'h8000_0000);
    assign key_b  = b[FP32_SIGN] ? ~b : (b ^ 32'h8000_0000);

    assign a_lt_b = key_a < key_b;
    assign a_gt_b = key_a > key_b;

    assign a_nan  = (a[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (a[MANT_MSB:0] != '0);
    assign b_nan  = (b[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (b[MANT_MSB:0] != '0);

endmodule

// File: rtl/minmax_scanner.sv
// Buffers a batch of fp32 samples, tracks min/max, then replays each sample to the normalizer.
//   state | meaning
//   IDLE  | waiting for first sample of a batch
//   LOAD  | accepting further samples, updating min/max
//   FINAL | batch closed, resolve flat, point replay at index 0
//   ISSUE | sample presented, start normalizer once it is not busy
//   WAIT  | waiting for the normalizer result
//   DONE  | batch replayed, clear count
module minmax_scanner
    import fp32_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              norm_start,
    input  logic              norm_busy,
    input  logic              norm_valid,
    input  logic [31:0]       norm_result,
    output logic [31:0]       sample_out,
    output logic [31:0]       max_out,
    output logic [31:0]       min_out,
    output logic              res_valid,
    output logic [31:0]       res_data,
    output logic [ADDR_W-1:0] res_index,
    output logic              flat,
    output logic              nan_seen,
    output logic              done
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    scan_state_e       state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [31:0]       min_q, min_d, max_q, max_d, sample_q, sample_d;
    logic [31:0]       res_data_q, res_data_d;
    logic [ADDR_W-1:0] res_index_q, res_index_d;
    logic              have_num_q, have_num_d, flat_q, flat_d, nan_q, nan_d;
    logic              start_q, start_d, res_valid_q, res_valid_d, done_q, done_d;
    logic [31:0]       mem_q [DEPTH];

    logic accept, samp_nan, lt_min, gt_max;
    logic unused_gt_min, unused_nan_min, unused_lt_max, unused_a_nan_max, unused_b_nan_max;

    fp32_cmp u_cmp_min (
        .a(in_data), .b(min_q), .a_lt_b(lt_min), .a_gt_b(unused_gt_min),
        .a_nan(samp_nan), .b_nan(unused_nan_min)
    );

    fp32_cmp u_cmp_max (
        .a(in_data), .b(max_q), .a_lt_b(unused_lt_max), .a_gt_b(gt_max),
        .a_nan(unused_a_nan_max), .b_nan(unused_b_nan_max)
    );

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_d        = rd_q;
        min_d       = min_q;
        max_d       = max_q;
        sample_d    = sample_q;
        res_data_d  = res_data_q;
        res_index_d = res_index_q;
        have_num_d  = have_num_q;
        flat_d      = flat_q;
        nan_d       = nan_q;
        start_d     = 1'b0;
        res_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    count_d = count_q + 1'b1;
                    flat_d  = 1'b0;
                    if (samp_nan) begin
                        min_d      = QNAN;
                        max_d      = QNAN;
                        have_num_d = 1'b0;
                        nan_d      = 1'b1;
                    end else begin
                        min_d      = in_data;
                        max_d      = in_data;
                        have_num_d = 1'b1;
                        nan_d      = 1'b0;
                    end
                    state_d = in_last ? ST_FINAL : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    count_d = count_q + 1'b1;
                    if (samp_nan) begin
                        nan_d = 1'b1;
                    end else if (!have_num_q) begin
                        // First numeric sample replaces the all-NaN default
                        min_d      = in_data;
                        max_d      = in_data;
                        have_num_d = 1'b1;
                    end else begin
                        if (lt_min) min_d = in_data;
                        if (gt_max) max_d = in_data;
                    end
                    if (in_last || count_q == LAST_CNT) state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                flat_d   = (min_q == max_q) || ((min_q[30:0] == '0) && (max_q[30:0] == '0));
                rd_d     = '0;
                sample_d = mem_q[0];
                state_d  = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!norm_busy) begin
                    start_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (norm_valid) begin
                    res_data_d  = norm_result;
                    res_index_d = rd_q;
                    res_valid_d = 1'b1;
                    if ({1'b0, rd_q} == count_q - 1'b1) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        rd_d     = rd_q + 1'b1;
                        sample_d = mem_q[rd_q + 1'b1];
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            rd_q        <= '0;
            min_q       <= '0;
            max_q       <= '0;
            sample_q    <= '0;
            res_data_q  <= '0;
            res_index_q <= '0;
            have_num_q  <= 1'b0;
            flat_q      <= 1'b0;
            nan_q       <= 1'b0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            min_q       <= min_d;
            max_q       <= max_d;
            sample_q    <= sample_d;
            res_data_q  <= res_data_d;
            res_index_q <= res_index_d;
            have_num_q  <= have_num_d;
            flat_q      <= flat_d;
            nan_q       <= nan_d;
            start_q     <= start_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[count_q[ADDR_W-1:0]] <= in_data;
    end

    assign norm_start = start_q;
    assign sample_out = sample_q;
    assign max_out    = max_q;
    assign min_out    = min_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_index  = res_index_q;
    assign flat       = flat_q;
    assign nan_seen   = nan_q;
    assign done       = done_q;

endmodule

// File: tb/tb_minmax_scanner.sv
// Directed bench for minmax_scanner with a small fixed-latency normalizer stand-in.
module tb_minmax_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic [31:0] in_data = '0;
    logic        norm_busy = 1'b0, norm_valid = 1'b0;
    logic [31:0] norm_result = '0;
    logic        in_ready, norm_start, res_valid, flat, nan_seen, done;
    logic [31:0] sample_out, max_out, min_out, res_data;
    logic [3:0]  res_index;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_s [16];

    minmax_scanner #(.ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .norm_start(norm_start),
        .norm_busy(norm_busy), .norm_valid(norm_valid), .norm_result(norm_result),
        .sample_out(sample_out), .max_out(max_out), .min_out(min_out),
        .res_valid(res_valid), .res_data(res_data), .res_index(res_index),
        .flat(flat), .nan_seen(nan_seen), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams n samples from exp_s back to back, in_last on the final one when set_last.
    task automatic stream(input int n, input bit set_last);
        for (int i = 0; i < n; i++) begin
            check("in_ready_before_accept", in_ready, 1);
            in_valid = 1'b1;
            in_data  = exp_s[i];
            in_last  = set_last && (i == n - 1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("in_ready_after_last", in_ready, 0);
    endtask

    // Plays the normalizer for n replays: busy 3 cycles, then a valid carrying sample ^ 0F0F0F0F.
    task automatic serve(input int n);
        int cyc;
        for (int i = 0; i < n; i++) begin
            cyc = 0;
            while (norm_start !== 1'b1 && cyc < 50) begin
                step();
                cyc++;
            end
            check("norm_start_seen", norm_start, 1);
            if (i > 0) check("start_after_valid_latency", cyc, 1);
            check("sample_at_start", sample_out, exp_s[i]);
            norm_busy = 1'b1;
            repeat (3) step();
            check("start_one_cycle", norm_start, 0);
            check("sample_stable", sample_out, exp_s[i]);
            norm_busy   = 1'b0;
            norm_valid  = 1'b1;
            norm_result = exp_s[i] ^ 32'h0F0F_0F0F;
            step();
            norm_valid = 1'b0;
            check("res_valid", res_valid, 1);
            check("res_data", res_data, exp_s[i] ^ 32'h0F0F_0F0F);
            check("res_index", res_index, i);
            check("done_flag", done, (i == n - 1) ? 1 : 0);
        end
        step();
        check("done_one_cycle", done, 0);
        check("res_valid_one_cycle", res_valid, 0);
        step();
        check("back_to_idle", in_ready, 1);
    endtask

    initial begin
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_norm_start", norm_start, 0);
        check("rst_max", max_out, 0);
        check("rst_min", min_out, 0);
        check("rst_flags", {res_valid, flat, nan_seen, done}, 0);
        step();
        rst = 1'b0;
        step();

        // Mixed-sign batch of three
        exp_s[0] = 32'h4000_0000; exp_s[1] = 32'hBF80_0000; exp_s[2] = 32'h4040_0000;
        stream(3, 1);
        check("t1_min", min_out, 32'hBF80_0000);
        check("t1_max", max_out, 32'h4040_0000);
        serve(3);
        check("t1_flat", flat, 0);
        check("t1_nan", nan_seen, 0);

        // Full buffer, implicit last
        exp_s = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                  32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
                  32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000,
                  32'h4150_0000, 32'h4160_0000, 32'h4170_0000, 32'h4180_0000};
        stream(16, 0);
        step();
        check("t2_no_start_yet", norm_start, 0);
        step();
        check("t2_start_2_cycles", norm_start, 1);
        serve(16);
        check("t2_min", min_out, 32'h3F80_0000);
        check("t2_max", max_out, 32'h4180_0000);

        // Leading NaN is replayed but excluded from min/max
        exp_s[0] = 32'h7FC0_0000; exp_s[1] = 32'h3F80_0000; exp_s[2] = 32'h3F00_0000;
        stream(3, 1);
        check("t3_min", min_out, 32'h3F00_0000);
        check("t3_max", max_out, 32'h3F80_0000);
        check("t3_nan", nan_seen, 1);
        serve(3);
        check("t3_flat", flat, 0);

        // Equal samples, then signed zeros
        exp_s[0] = 32'h3F80_0000; exp_s[1] = 32'h3F80_0000;
        stream(2, 1);
        serve(2);
        check("t4a_flat", flat, 1);
        check("t4a_nan_cleared", nan_seen, 0);
        exp_s[0] = 32'h8000_0000; exp_s[1] = 32'h0000_0000;
        stream(2, 1);
        serve(2);
        check("t4b_min", min_out, 32'h8000_0000);
        check("t4b_max", max_out, 32'h0000_0000);
        check("t4b_flat", flat, 1);

        // Busy hold in ISSUE with a stray norm_valid
        exp_s[0] = 32'h4000_0000; exp_s[1] = 32'h4080_0000;
        norm_busy = 1'b1;
        stream(2, 1);
        for (int c = 0; c < 10; c++) begin
            norm_valid = (c == 5);
            step();
            check("t5_no_start", norm_start, 0);
            check("t5_sample_hold", sample_out, 32'h4000_0000);
            check("t5_stray_valid_ignored", res_valid, 0);
        end
        norm_valid = 1'b0;
        norm_busy  = 1'b0;
        step();
        check("t5_start_on_release", norm_start, 1);
        serve(2);

        // Reset during WAIT, then a single-sample batch
        exp_s[0] = 32'h4000_0000; exp_s[1] = 32'h4040_0000; exp_s[2] = 32'h4080_0000;
        stream(3, 1);
        step();
        step();
        check("t6_in_wait", norm_start, 1);
        step();
        rst = 1'b1;
        #2;
        check("t6_rst_in_ready", in_ready, 1);
        check("t6_rst_outputs", {norm_start, res_valid, flat, nan_seen, done}, 0);
        check("t6_rst_sample", sample_out, 0);
        check("t6_rst_max", max_out, 0);
        check("t6_rst_min", min_out, 0);
        check("t6_rst_res", {res_data, 4'(res_index)}, 0);
        step();
        rst = 1'b0;
        step();
        exp_s[0] = 32'hC0A0_0000;
        stream(1, 1);
        check("t6_min", min_out, 32'hC0A0_0000);
        check("t6_max", max_out, 32'hC0A0_0000);
        serve(1);
        check("t6_flat", flat, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/minmax_scanner.md
Name: minmax_scanner

Overview:
Streaming front end for the fp32 normalizer.
- Accepts a batch of up to DEPTH IEEE-754 single-precision samples and stores them in an internal buffer.
- Tracks the running minimum and maximum of the batch.
- Replays each stored sample to the normalizer with stable max/min operands, using the normalizer's start/busy/valid handshake, and forwards each normalized result downstream.

Parameters:
ADDR_W, 4, buffer address width; DEPTH = 2**ADDR_W samples per batch.

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  upstream sample valid
in_ready  out  1  scanner can accept a sample
in_data  in  32  fp32 sample
in_last  in  1  marks final sample of batch
norm_start  out  1  one-cycle start pulse to normalizer
norm_busy  in  1  normalizer busy
norm_valid  in  1  normalizer result valid (one-cycle pulse)
norm_result  in  32  normalizer out_data
sample_out  out  32  sample fed to normalizer in_data
max_out  out  32  batch maximum, fed to normalizer max
min_out  out  32  batch minimum, fed to normalizer min
res_valid  out  1  one-cycle pulse, normalized result available
res_data  out  32  normalized result
res_index  out  ADDR_W  buffer index of res_data
flat  out  1  batch has max-min == 0 (normalizer divide-by-zero)
nan_seen  out  1  at least one NaN in batch
done  out  1  one-cycle pulse, batch fully replayed

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. Reset puts the state in IDLE. All outputs are 0, except in_ready, which is decoded from state.
- rst mid-operation aborts the batch. The buffer contents become don't-care and count is cleared.
- Outputs are driven from registers/state only; there are no combinational input-to-output paths.
- States: IDLE, LOAD, FINAL, ISSUE, WAIT, DONE.
- in_ready = 1 in IDLE and LOAD, 0 otherwise.
- Accept occurs when in_valid && in_ready. Each accept writes buf[count] and increments count (ADDR_W+1 bits).
- IDLE, on accept:
  - min/max are initialised to the sample (NaN: see below).
  - flat and nan_seen are cleared.
  - Next state is LOAD, or FINAL if in_last is set.
- LOAD, on accept: update min/max. Go to FINAL on in_last, or when the DEPTH-th sample is accepted (implicit last).
- Ordering: total order via key = sign ? ~x : x ^ 32'h80000000, unsigned compare. Consequently -0 < +0.
  - Strict compare: on ties, the earlier sample is kept.
- NaN (exp == 8'hFF, mant != 0):
  - stored and replayed;
  - excluded from min/max;
  - sets nan_seen.
- If every sample is NaN, min = max = 32'h7FC00000 and flat = 1. ±Inf participates normally.
- FINAL (1 cycle): flat = (min == max) or (both have exp == 0 and mant == 0). rd = 0. Next state is ISSUE.
- ISSUE:
  - sample_out = buf[rd].
  - If !norm_busy: pulse norm_start and go to WAIT.
  - If norm_busy: hold, with no start pulse.
- WAIT: norm_start = 0. On norm_valid:
  - res_data = norm_result;
  - res_index = rd;
  - pulse res_valid next cycle;
  - if rd == count-1, go to DONE; otherwise rd++ and go to ISSUE.
- sample_out, max_out and min_out are held stable from ISSUE entry until norm_valid. This is required because the normalizer samples max mid-operation.
- flat does not suppress replay. The downstream consumer decides what to do with results when flat = 1.
- DONE: done = 1 for one cycle, count = 0, then IDLE.
- max_out, min_out, flat and nan_seen keep their values until the next batch's first accept.
- Latency:
  - first norm_start is 2 cycles after the last accept;
  - each subsequent norm_start is 1 cycle after the preceding norm_valid (given norm_busy = 0).
- A norm_valid received outside WAIT is ignored.

Decomposition:
- Shared package fp32_pkg holds:
  - FP32_SIGN = 31;
  - exponent field [30:23], mantissa field [22:0];
  - EXP_ALL_ONES = 8'hFF;
  - QNAN = 32'h7FC00000;
  - the state enum.
- One combinational sub-module, fp32_cmp:
  - inputs: a, b;
  - outputs: a_lt_b, a_gt_b, a_nan, b_nan.
  - It performs the key transform and is reusable by other ALU blocks.
- The buffer is an inferred register array inside minmax_scanner.

Test Plan:
1. Accept {40000000, BF800000, 40400000(last)} with normalizer model → min_out = BF800000, max_out = 40400000, flat = 0. norm_start pulses carry sample_out = 40000000, BF800000, 40400000 in order. res_index = 0, 1, 2, followed by a done pulse.
2. Stream 16 samples 3F800000..41800000 with no in_last → in_ready = 0 the cycle after the 16th accept. 16 replays, done once; first norm_start exactly 2 cycles after the 16th accept.
3. Stream {7FC00000, 3F800000, 3F000000(last)} → min = 3F000000, max = 3F800000, nan_seen = 1. Three replays, index 0 carrying 7FC00000.
4. Stream {3F800000, 3F800000(last)} → flat = 1. Stream {80000000, 00000000(last)} → min = 80000000, max = 00000000, flat = 1.
5. Hold norm_busy = 1 for 10 cycles in ISSUE → no norm_start, sample_out stable. Release → one norm_start next cycle. Spurious norm_valid in ISSUE → ignored.
6. Assert rst during WAIT of a 3-sample batch → all outputs 0, state IDLE. A new 1-sample batch completes with correct min = max = sample, flat = 1.
